// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline front end.
// Contents:
//   FETCH_*          2-bit encodings of the fetch sequencer states
//   fetch_state_e    enum built on those encodings
//   DEFAULT_RESET_PC PC loaded on reset unless overridden
//   PC_INCR          sequential fetch stride in bytes
//   PC_ALIGN_MASK    clears the byte-offset bits of an address
package mips_pkg;

    localparam logic [1:0] FETCH_IDLE = 2'd0;
    localparam logic [1:0] FETCH_REQ  = 2'd1;
    localparam logic [1:0] FETCH_WAIT = 2'd2;
    localparam logic [1:0] FETCH_HOLD = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = FETCH_IDLE,
        S_REQ  = FETCH_REQ,
        S_WAIT = FETCH_WAIT,
        S_HOLD = FETCH_HOLD
    } fetch_state_e;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] PC_INCR          = 32'd4;
    localparam logic [31:0] PC_ALIGN_MASK    = 32'hFFFF_FFFC;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry holding register for a fetched word that arrived while decode
// was stalled.
// Ports:
//   clock, reset      clock and asynchronous active-low reset
//   load_i            capture {instr_i, pc_i} and mark the entry valid
//   clear_i           entry consumed; drop the valid bit
//   flush_i           pipeline flush; drop the entry and zero its contents
//   instr_i, pc_i     word and its address to capture
//   valid_o           entry holds a live word
//   instr_o, pc_o     held word and its address
module fetch_skid_buf
    import mips_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        load_i,
    input  logic        clear_i,
    input  logic        flush_i,
    input  logic [31:0] instr_i,
    input  logic [31:0] pc_i,
    output logic        valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o
);

    logic        valid_q;
    logic [31:0] instr_q;
    logic [31:0] pc_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_q <= 1'b0;
            instr_q <= '0;
            pc_q    <= '0;
        end else if (flush_i) begin
            valid_q <= 1'b0;
            instr_q <= '0;
            pc_q    <= '0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            instr_q <= instr_i;
            pc_q    <= pc_i;
        end else if (clear_i) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign instr_o = instr_q;
    assign pc_o    = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues one word fetch at a time over
// a req/ready + rvalid handshake and feeds the IF/ID pipeline register.
// Honours decode stalls and branch/jump redirects from EX.
//
// Optional build macro: FETCH_PERF_EN adds perf_fetched / perf_stalled.
//
// Ports:
//   clock, reset         clock; asynchronous active-low reset
//   stall                decode cannot accept; IF/ID holds
//   redirect, redirect_pc  taken branch/jump and its target (bits [1:0] ignored)
//   imem_req, imem_addr  fetch request and word-aligned address (= PC)
//   imem_ready           memory accepts the request this cycle
//   imem_rvalid, imem_rdata  response strobe and fetched word
//   id_valid, id_instruction, id_pc, id_pc_plus4  IF/ID register outputs
//   perf_fetched, perf_stalled  event counters (FETCH_PERF_EN only)
//
// state | meaning
// IDLE  | leaving reset, no request yet
// REQ   | imem_req high at PC, waiting for imem_ready
// WAIT  | one request outstanding, waiting for imem_rvalid
// HOLD  | fetched word parked in skid buffer until decode unstalls
module fetch_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        id_valid,
    output logic [31:0] id_instruction,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_plus4
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stalled
`endif
);

    localparam logic [31:0] RESET_PC_ALIGNED = RESET_PC & PC_ALIGN_MASK;

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         drop_q, drop_d;

    logic         id_valid_q, id_valid_d;
    logic [31:0]  id_instr_q, id_instr_d;
    logic [31:0]  id_pc_q, id_pc_d;
    logic [31:0]  id_pc_plus4_q, id_pc_plus4_d;

    logic         skid_load, skid_clear, skid_flush;
    logic         skid_valid;
    logic [31:0]  skid_instr, skid_pc;

    // A request is still owed a response after this edge if we are waiting
    // and it has not arrived, or if one is being accepted right now.
    logic         rsp_in_flight;

    assign rsp_in_flight = ((state_q == S_WAIT) && !imem_rvalid) ||
                           ((state_q == S_REQ)  &&  imem_ready);

    fetch_skid_buf u_skid (
        .clock   (clock),
        .reset   (reset),
        .load_i  (skid_load),
        .clear_i (skid_clear),
        .flush_i (skid_flush),
        .instr_i (imem_rdata),
        .pc_i    (pc_q),
        .valid_o (skid_valid),
        .instr_o (skid_instr),
        .pc_o    (skid_pc)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            pc_q          <= RESET_PC_ALIGNED;
            drop_q        <= 1'b0;
            id_valid_q    <= 1'b0;
            id_instr_q    <= '0;
            id_pc_q       <= '0;
            id_pc_plus4_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            drop_q        <= drop_d;
            id_valid_q    <= id_valid_d;
            id_instr_q    <= id_instr_d;
            id_pc_q       <= id_pc_d;
            id_pc_plus4_q <= id_pc_plus4_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        drop_d        = drop_q;
        // With decode free and nothing loaded this cycle, IF/ID becomes a bubble.
        id_valid_d    = stall ? id_valid_q : 1'b0;
        id_instr_d    = id_instr_q;
        id_pc_d       = id_pc_q;
        id_pc_plus4_d = id_pc_plus4_q;
        skid_load     = 1'b0;
        skid_clear    = 1'b0;
        skid_flush    = 1'b0;

        if (redirect) begin
            id_valid_d = 1'b0;
            skid_flush = 1'b0 | 1'b1;
            pc_d       = redirect_pc & PC_ALIGN_MASK;
            // The stale response still has to be swallowed before the target
            // can be requested; a second redirect reuses the same pending drop.
            if (rsp_in_flight) begin
                drop_d  = 1'b1;
                state_d = S_WAIT;
            end else begin
                drop_d  = 1'b0;
                state_d = S_REQ;
            end
        end else begin
            case (state_q)
                S_IDLE: state_d = S_REQ;
                S_REQ: begin
                    if (imem_ready) state_d = S_WAIT;
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        if (drop_q) begin
                            drop_d  = 1'b0;
                            state_d = S_REQ;
                        end else begin
                            pc_d = pc_q + PC_INCR;
                            if (!stall) begin
                                id_valid_d    = 1'b1;
                                id_instr_d    = imem_rdata;
                                id_pc_d       = pc_q;
                                id_pc_plus4_d = pc_q + PC_INCR;
                                state_d       = S_REQ;
                            end else begin
                                skid_load = 1'b1;
                                state_d   = S_HOLD;
                            end
                        end
                    end
                end
                S_HOLD: begin
                    if (!stall) begin
                        id_valid_d    = skid_valid;
                        id_instr_d    = skid_instr;
                        id_pc_d       = skid_pc;
                        id_pc_plus4_d = skid_pc + PC_INCR;
                        skid_clear    = 1'b1;
                        state_d       = S_REQ;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign imem_req       = (state_q == S_REQ);
    assign imem_addr      = pc_q;
    assign id_valid       = id_valid_q;
    assign id_instruction = id_instr_q;
    assign id_pc          = id_pc_q;
    assign id_pc_plus4    = id_pc_plus4_q;

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched_q;
    logic [31:0] perf_stalled_q;
    logic        live_load;

    // With stall low, id_valid_d can only be set by an actual IF/ID load.
    assign live_load = !stall && id_valid_d;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            perf_fetched_q <= '0;
            perf_stalled_q <= '0;
        end else begin
            if (live_load)            perf_fetched_q <= perf_fetched_q + 32'd1;
            if (stall && id_valid_q)  perf_stalled_q <= perf_stalled_q + 32'd1;
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_stalled = perf_stalled_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        id_valid;
    logic [31:0] id_instruction, id_pc, id_pc_plus4;

    // second instance: reset PC at the top of the address space
    logic        w_stall = 1'b0;
    logic        w_redirect = 1'b0;
    logic [31:0] w_redirect_pc = 32'h0;
    logic        w_ready = 1'b1;
    logic        w_rvalid = 1'b0;
    logic [31:0] w_rdata = 32'h0C00_0000;
    logic        w_req;
    logic [31:0] w_addr;
    logic        w_id_valid;
    logic [31:0] w_id_instr, w_id_pc, w_id_pc_plus4;

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched, perf_stalled;
    logic [31:0] w_perf_fetched, w_perf_stalled;
`endif

    always #5 clock = ~clock;

    fetch_stage u_dut (
        .clock          (clock),
        .reset          (reset),
        .stall          (stall),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .id_valid       (id_valid),
        .id_instruction (id_instruction),
        .id_pc          (id_pc),
        .id_pc_plus4    (id_pc_plus4)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_stalled   (perf_stalled)
`endif
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) u_dut_wrap (
        .clock          (clock),
        .reset          (reset),
        .stall          (w_stall),
        .redirect       (w_redirect),
        .redirect_pc    (w_redirect_pc),
        .imem_req       (w_req),
        .imem_addr      (w_addr),
        .imem_ready     (w_ready),
        .imem_rvalid    (w_rvalid),
        .imem_rdata     (w_rdata),
        .id_valid       (w_id_valid),
        .id_instruction (w_id_instr),
        .id_pc          (w_id_pc),
        .id_pc_plus4    (w_id_pc_plus4)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched   (w_perf_fetched),
        .perf_stalled   (w_perf_stalled)
`endif
    );

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    // instruction memory contents: low two bits 2'b11 (or 2'b01 at 0x0),
    // spurious responses always carry 2'b10 so they can never pass as real
    function automatic logic [31:0] memf(input logic [31:0] a);
        logic [31:0] r;
        if (a == 32'h0) r = 32'h2008_0005;
        else begin
            r = ~a;
            r[1:0] = 2'b11;
        end
        return r;
    endfunction

    // reference model state (transaction level)
    logic [31:0] exp_fetch, exp_deliver;
    bit          outstanding;
    logic [31:0] out_addr;
    int unsigned lat;
    int unsigned ready_pct, lat_max;
    bit          hold_rsp, spur_en;
    int unsigned n_deliv;
    logic [31:0] exp_perf_f, exp_perf_s;
    logic        po_req, po_valid;
    logic [31:0] po_addr, po_instr, po_pc, po_plus4;
    logic        w_prev_req;
    bit          w_checked;

    task automatic save_outputs();
        po_req   = imem_req;
        po_addr  = imem_addr;
        po_valid = id_valid;
        po_instr = id_instruction;
        po_pc    = id_pc;
        po_plus4 = id_pc_plus4;
    endtask

    // one clock: evaluate what the last edge did, then drive the next cycle
    task automatic step();
        logic [31:0] junk;
        @(negedge clock);
        if (imem_rvalid && outstanding) outstanding = 1'b0;
        if (po_req && imem_ready) begin
            chk("single_outstanding", {31'd0, outstanding}, 32'd0);
            chk("fetch_addr", po_addr, exp_fetch);
            exp_fetch   = exp_fetch + 32'd4;
            outstanding = 1'b1;
            out_addr    = po_addr;
            lat         = $urandom_range(lat_max, 0);
        end
        if (redirect) begin
            exp_fetch   = redirect_pc & 32'hFFFF_FFFC;
            exp_deliver = exp_fetch;
            chk("flush_valid", {31'd0, id_valid}, 32'd0);
        end else if (stall) begin
            chk("hold_valid", {31'd0, id_valid}, {31'd0, po_valid});
            chk("hold_instr", id_instruction, po_instr);
            chk("hold_pc", id_pc, po_pc);
            chk("hold_plus4", id_pc_plus4, po_plus4);
        end else if (id_valid) begin
            chk("deliver_pc", id_pc, exp_deliver);
            chk("deliver_instr", id_instruction, memf(exp_deliver));
            chk("deliver_plus4", id_pc_plus4, exp_deliver + 32'd4);
            exp_deliver = exp_deliver + 32'd4;
            exp_perf_f  = exp_perf_f + 32'd1;
            n_deliv++;
        end
        if (stall && po_valid) exp_perf_s = exp_perf_s + 32'd1;
`ifdef FETCH_PERF_EN
        chk("perf_fetched", perf_fetched, exp_perf_f);
        chk("perf_stalled", perf_stalled, exp_perf_s);
`endif
        save_outputs();

        imem_ready  = ($urandom_range(99, 0) < ready_pct);
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        if (outstanding) begin
            if (!hold_rsp) begin
                if (lat == 0) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = memf(out_addr);
                end else lat--;
            end
        end else if (spur_en && $urandom_range(9, 0) == 0) begin
            junk        = $urandom();
            junk[1:0]   = 2'b10;
            imem_rvalid = 1'b1;
            imem_rdata  = junk;
        end

        if (w_id_valid && !w_checked) begin
            chk("wrap_pc", w_id_pc, 32'hFFFF_FFFC);
            chk("wrap_plus4", w_id_pc_plus4, 32'h0);
            chk("wrap_next_req", {31'd0, w_req}, 32'd1);
            chk("wrap_next_addr", w_addr, 32'h0);
            w_checked = 1'b1;
        end
        w_rvalid   = w_prev_req;
        w_prev_req = w_req;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!id_valid && n < 40) begin
            step();
            n++;
        end
        chk(tag, {31'd0, id_valid}, 32'd1);
    endtask

    task automatic wait_req(input string tag);
        int n = 0;
        while (!imem_req && n < 40) begin
            step();
            n++;
        end
        chk(tag, {31'd0, imem_req}, 32'd1);
    endtask

    initial begin
        exp_fetch = 32'h0; exp_deliver = 32'h0;
        outstanding = 1'b0; out_addr = 32'h0; lat = 0;
        ready_pct = 100; lat_max = 0; hold_rsp = 1'b0; spur_en = 1'b0;
        n_deliv = 0; exp_perf_f = 32'h0; exp_perf_s = 32'h0;
        w_prev_req = 1'b0; w_checked = 1'b0;

        repeat (3) @(negedge clock);
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_valid", {31'd0, id_valid}, 32'd0);
        chk("rst_instr", id_instruction, 32'h0);
        chk("rst_pc", id_pc, 32'h0);
        chk("rst_plus4", id_pc_plus4, 32'h0);
        chk("rst_wrap_addr", w_addr, 32'hFFFF_FFFC);
`ifdef FETCH_PERF_EN
        chk("rst_perf_fetched", perf_fetched, 32'h0);
        chk("rst_perf_stalled", perf_stalled, 32'h0);
`endif
        reset = 1'b1;
        save_outputs();

        // first request one cycle after release, zero-wait memory
        step();
        chk("first_req", {31'd0, imem_req}, 32'd1);
        chk("first_addr", imem_addr, 32'h0);
        wait_valid("first_fetch_valid");
        chk("first_instr", id_instruction, 32'h2008_0005);
        chk("first_pc", id_pc, 32'h0);
        chk("first_plus4", id_pc_plus4, 32'h4);

        // stall across the response for 0x4
        stall = 1'b1;
        step();
        step();
        chk("stall_pc_a", id_pc, 32'h0);
        chk("stall_req_a", {31'd0, imem_req}, 32'd0);
        step();
        chk("stall_pc_b", id_pc, 32'h0);
        chk("stall_req_b", {31'd0, imem_req}, 32'd0);
        stall = 1'b0;
        step();
        chk("unstall_pc", id_pc, 32'h4);
        chk("unstall_valid", {31'd0, id_valid}, 32'd1);

        // redirect while waiting for 0x8
        wait_req("req_8");
        chk("req_8_addr", imem_addr, 32'h8);
        hold_rsp = 1'b1;
        step();
        redirect = 1'b1; redirect_pc = 32'h0000_0101;
        step();
        redirect = 1'b0;
        chk("redir_flush", {31'd0, id_valid}, 32'd0);
        hold_rsp = 1'b0;
        step();
        chk("redir_wait_valid", {31'd0, id_valid}, 32'd0);
        chk("redir_wait_req", {31'd0, imem_req}, 32'd0);
        step();
        chk("redir_req", {31'd0, imem_req}, 32'd1);
        chk("redir_addr", imem_addr, 32'h0000_0100);
        chk("redir_bubble", {31'd0, id_valid}, 32'd0);
        wait_valid("redir_fetch_valid");
        chk("redir_pc", id_pc, 32'h0000_0100);

        // redirect together with stall and an accepted request
        wait_req("req_104");
        stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_0200;
        step();
        chk("rs_flush", {31'd0, id_valid}, 32'd0);
        stall = 1'b0; redirect = 1'b0;
        wait_req("rs_req");
        chk("rs_addr", imem_addr, 32'h0000_0200);
        wait_valid("rs_fetch_valid");
        chk("rs_pc", id_pc, 32'h0000_0200);

        // randomized traffic against the model
        ready_pct = 70; lat_max = 3; spur_en = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            stall    = ($urandom_range(99, 0) < 25);
            redirect = ($urandom_range(99, 0) < 4);
            redirect_pc = $urandom();
            step();
        end
        stall = 1'b0; redirect = 1'b0;
        step();

        chk("enough_deliveries", {31'd0, n_deliv > 200}, 32'd1);
        chk("wrap_seen", {31'd0, w_checked}, 32'd1);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
